// File: rtl/mac_result_collector.sv
// Collects MAC results one cycle after mac_en, frames accumulate groups, and
// queues entries in a show-ahead FIFO feeding a valid/ready stream.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif

module mac_result_collector #(
  parameter int ACC_W = `MAC_ACC_WIDTH,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mac_en,
  input  logic             acc_sel,
  input  logic [LEN_W-1:0] acc_len,
  input  logic [ACC_W-1:0] c,
  input  logic             clear,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow,
  output logic [LEN_W-1:0] beat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic             v_q, v_d, s_q, s_d;
  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [ACC_W:0]   mem_q [DEPTH];

  logic push, push_last, push_ok, pop, empty, full;

  // Beat capture and accumulate-group framing.
  always_comb begin
    v_d       = clear ? 1'b0 : mac_en;
    s_d       = acc_sel;
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_last = 1'b0;
    cnt_inc   = cnt_q + LEN_W'(1);
    if (v_q && !clear) begin
      if (!s_q) begin
        push    = 1'b1;
        state_d = IDLE;
        if (state_q == ACCUM) cnt_d = '0;
      end else if (state_q == IDLE) begin
        len_d = (acc_len == '0) ? LEN_W'(1) : acc_len;
        if (len_d == LEN_W'(1)) begin
          push      = 1'b1;
          push_last = 1'b1;
        end else begin
          cnt_d   = LEN_W'(1);
          state_d = ACCUM;
        end
      end else if (cnt_inc == len_q) begin
        push      = 1'b1;
        push_last = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (clear) begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && out_ready && !clear;
  assign push_ok = push && (!full || pop);

  // Head register is loaded from the post-update FIFO; a push landing on the
  // new head slot is forwarded since the array write happens on the same edge.
  always_comb begin
    wr_d       = clear ? '0 : wr_q + {{AW{1'b0}}, push_ok};
    rd_d       = clear ? '0 : rd_q + {{AW{1'b0}}, pop};
    overflow_d = clear ? 1'b0 : (overflow_q | (push && full && !pop));
    data_d     = data_q;
    last_d     = last_q;
    if (wr_d != rd_d) begin
      if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
        data_d = c;
        last_d = push_last;
      end else begin
        {last_d, data_d} = mem_q[rd_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= 1'b0;
      s_q        <= 1'b0;
      state_q    <= IDLE;
      len_q      <= LEN_W'(1);
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      v_q        <= v_d;
      s_q        <= s_d;
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_q[AW-1:0]] <= {push_last, c};
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = !empty;
  assign overflow  = overflow_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: capture latency, accumulate framing,
// backpressure/overflow, mode switch, clear and asynchronous reset.
module tb_mac_result_collector;

  localparam int ACC_W = 32;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             mac_en = 1'b0;
  logic             acc_sel = 1'b0;
  logic [LEN_W-1:0] acc_len = '0;
  logic [ACC_W-1:0] c = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             overflow;
  logic [LEN_W-1:0] beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mac_result_collector #(.ACC_W(ACC_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .mac_en(mac_en), .acc_sel(acc_sel), .acc_len(acc_len),
    .c(c), .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: mac_en in the first cycle, c sampled in the second.
  task automatic beat(input logic sel, input logic [ACC_W-1:0] cv);
    mac_en  = 1'b1;
    acc_sel = sel;
    tick();
    mac_en = 1'b0;
    c      = cv;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Multiply-only stream, two-cycle latency.
    out_ready = 1'b1;
    acc_sel   = 1'b0;
    mac_en    = 1'b1;
    tick();
    chk("t1_c1_valid", out_valid, 0);
    c = 32'h11;
    tick();
    chk("t1_c2_valid", out_valid, 1);
    chk("t1_c2_data", out_data, 32'h11);
    chk("t1_c2_last", out_last, 0);
    c = 32'h22;
    tick();
    mac_en = 1'b0;
    chk("t1_c3_data", out_data, 32'h22);
    c = 32'h33;
    tick();
    chk("t1_c4_valid", out_valid, 1);
    chk("t1_c4_data", out_data, 32'h33);
    chk("t1_c4_last", out_last, 0);
    c = '0;
    tick();
    chk("t1_c5_valid", out_valid, 0);

    // Accumulate groups of 3.
    acc_len = 8'd3;
    beat(1'b1, 32'd5);
    chk("t2_cnt1", beat_cnt, 1);
    chk("t2_valid1", out_valid, 0);
    beat(1'b1, 32'd12);
    chk("t2_cnt2", beat_cnt, 2);
    chk("t2_valid2", out_valid, 0);
    beat(1'b1, 32'd30);
    chk("t2_cnt3", beat_cnt, 0);
    chk("t2_valid3", out_valid, 1);
    chk("t2_data3", out_data, 32'd30);
    chk("t2_last3", out_last, 1);
    tick();
    chk("t2_single", out_valid, 0);
    beat(1'b1, 32'd1);
    beat(1'b1, 32'd2);
    chk("t2b_valid2", out_valid, 0);
    beat(1'b1, 32'd3);
    chk("t2b_data", out_data, 32'd3);
    chk("t2b_last", out_last, 1);
    tick();
    chk("t2b_single", out_valid, 0);

    // acc_len of 0 behaves as 1.
    acc_len = 8'd0;
    beat(1'b1, 32'd7);
    chk("t3_data7", out_data, 32'd7);
    chk("t3_last7", out_last, 1);
    chk("t3_valid7", out_valid, 1);
    beat(1'b1, 32'd9);
    chk("t3_data9", out_data, 32'd9);
    chk("t3_last9", out_last, 1);
    chk("t3_cnt", beat_cnt, 0);
    tick();
    chk("t3_empty", out_valid, 0);

    // Backpressure and overflow.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(1'b0, i);
    chk("t4_head", out_data, 1);
    chk("t4_ovf0", overflow, 0);
    beat(1'b0, 32'd5);
    chk("t4_ovf1", overflow, 1);
    chk("t4_head5", out_data, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_valid", out_valid, 1);
      chk("t4_drain_data", out_data, i);
      tick();
    end
    chk("t4_drained", out_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);

    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clr_ovf", overflow, 0);
    for (int i = 10; i <= 13; i++) beat(1'b0, i);
    mac_en  = 1'b1;
    acc_sel = 1'b0;
    tick();
    mac_en    = 1'b0;
    c         = 32'd14;
    out_ready = 1'b1;
    tick();
    chk("t4_pp_ovf", overflow, 0);
    for (int i = 11; i <= 14; i++) begin
      chk("t4_pp_data", out_data, i);
      tick();
    end
    chk("t4_pp_empty", out_valid, 0);

    // Mid-group mode switch.
    out_ready = 1'b0;
    acc_len   = 8'd4;
    beat(1'b1, 32'h10);
    beat(1'b1, 32'h20);
    chk("t5_cnt2", beat_cnt, 2);
    chk("t5_valid0", out_valid, 0);
    beat(1'b0, 32'h40);
    chk("t5_cnt0", beat_cnt, 0);
    chk("t5_data", out_data, 32'h40);
    chk("t5_last", out_last, 0);
    out_ready = 1'b1;
    tick();
    chk("t5_single", out_valid, 0);

    // Clear with entries queued and a group in progress.
    out_ready = 1'b0;
    beat(1'b0, 32'h50);
    beat(1'b0, 32'h60);
    beat(1'b1, 32'h01);
    chk("t5_head", out_data, 32'h50);
    chk("t5_cnt_pre", beat_cnt, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_valid", out_valid, 0);
    chk("t5_clr_ovf", overflow, 0);
    chk("t5_clr_cnt", beat_cnt, 0);
    mac_en  = 1'b1;
    acc_sel = 1'b0;
    tick();
    mac_en = 1'b0;
    clear  = 1'b1;
    c      = 32'h70;
    tick();
    clear = 1'b0;
    tick();
    chk("t5_clr_discard", out_valid, 0);
    acc_len = 8'd1;
    beat(1'b1, 32'h77);
    chk("t5_idle_data", out_data, 32'h77);
    chk("t5_idle_last", out_last, 1);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset while in ACCUM with three entries queued.
    out_ready = 1'b0;
    acc_len   = 8'd3;
    beat(1'b0, 32'd1);
    beat(1'b0, 32'd2);
    beat(1'b0, 32'd3);
    beat(1'b1, 32'd9);
    chk("t6_cnt", beat_cnt, 1);
    chk("t6_head", out_data, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_last", out_last, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_cnt0", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    acc_len = 8'd1;
    beat(1'b1, 32'h55);
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_data", out_data, 32'h55);
    chk("t6_post_last", out_last, 1);
    chk("t6_post_cnt", beat_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
